// File: rtl/dmac_pkg.sv
// Shared definitions for the DMA controller: register offsets, FSM states,
// fixed AXI attributes and the burst-size helper.
package dmac_pkg;

    localparam logic [11:0] REG_VERSION = 12'h000;
    localparam logic [11:0] REG_SRC     = 12'h100;
    localparam logic [11:0] REG_DST     = 12'h104;
    localparam logic [11:0] REG_LEN     = 12'h108;
    localparam logic [11:0] REG_START   = 12'h10C;
    localparam logic [11:0] REG_STATUS  = 12'h110;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RREQ,
        ST_RDATA,
        ST_WREQ,
        ST_WDATA,
        ST_WRESP
    } dmac_state_e;

    localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [3:0] AXI_ID         = 4'd0;
    localparam int         MAX_BURST      = 16;

    // Beats in the next burst: whatever is left, capped at the maximum burst.
    function automatic logic [4:0] burst_beats(input logic [30:0] remaining);
        return (remaining > 31'(MAX_BURST)) ? 5'(MAX_BURST) : remaining[4:0];
    endfunction

endpackage

// File: rtl/dmac_fifo.sv
// 16 x 32 synchronous FIFO with show-ahead read data.
module dmac_fifo (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push,
    input  logic [31:0] wdata,
    input  logic        pop,
    output logic [31:0] rdata,
    output logic        full,
    output logic        empty
);

    logic [31:0] mem [16];
    logic [3:0]  wptr;
    logic [3:0]  rptr;
    logic [4:0]  count;

    assign full  = (count == 5'd16);
    assign empty = (count == 5'd0);
    assign rdata = mem[rptr];

    // Storage array; contents are only meaningful between push and pop.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wptr] <= wdata;
        end
    end

    // Pointers and occupancy count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push && !full) begin
                wptr <= wptr + 4'd1;
            end
            if (pop && !empty) begin
                rptr <= rptr + 4'd1;
            end
            case ({push && !full, pop && !empty})
                2'b10:   count <= count + 5'd1;
                2'b01:   count <= count - 5'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/dmac_top.sv
// Single-channel APB-programmed DMA: copies LEN bytes from SRC to DST as
// 32-bit beats, one read burst into the FIFO followed by one write burst out
// of it, repeated until the whole length has moved.
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high; a valid, once raised, stays high with stable payload until
// that edge.
module dmac_top
    import dmac_pkg::*;
#(
    parameter logic [31:0] VERSION = 32'h0001_0101
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        psel_i,
    input  logic        penable_i,
    input  logic        pwrite_i,
    input  logic [11:0] paddr_i,
    input  logic [31:0] pwdata_i,
    output logic        pready_o,
    output logic [31:0] prdata_o,
    output logic        pslverr_o,
    output logic [3:0]  awid_o,
    output logic [31:0] awaddr_o,
    output logic [3:0]  awlen_o,
    output logic [2:0]  awsize_o,
    output logic [1:0]  awburst_o,
    output logic        awvalid_o,
    input  logic        awready_i,
    output logic [3:0]  wid_o,
    output logic [31:0] wdata_o,
    output logic [3:0]  wstrb_o,
    output logic        wlast_o,
    output logic        wvalid_o,
    input  logic        wready_i,
    input  logic [3:0]  bid_i,
    input  logic [1:0]  bresp_i,
    input  logic        bvalid_i,
    output logic        bready_o,
    output logic [3:0]  arid_o,
    output logic [31:0] araddr_o,
    output logic [3:0]  arlen_o,
    output logic [2:0]  arsize_o,
    output logic [1:0]  arburst_o,
    output logic        arvalid_o,
    input  logic        arready_i,
    input  logic [3:0]  rid_i,
    input  logic [31:0] rdata_i,
    input  logic [1:0]  rresp_i,
    input  logic        rlast_i,
    input  logic        rvalid_i,
    output logic        rready_o
);

    dmac_state_e state, state_nxt;

    logic [31:0] src_reg, dst_reg, len_reg;
    logic [31:0] cur_src, cur_dst;
    logic [30:0] remaining;
    logic [30:0] len_beats;
    logic [4:0]  cur_burst;
    logic [3:0]  wbeat;
    logic        apb_wr, start_ok;
    logic        fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [31:0] fifo_rdata;
    logic        unused_resp;

    // IDs and responses carry no information for a single in-order channel.
    assign unused_resp = ^{bid_i, bresp_i, rid_i, rresp_i};

    assign pready_o  = 1'b1;
    assign pslverr_o = 1'b0;
    assign apb_wr    = psel_i & penable_i & pwrite_i;
    assign start_ok  = apb_wr && (paddr_i == REG_START) && pwdata_i[0]
                       && (state == ST_IDLE) && (len_reg != 32'd0);
    assign len_beats = 31'((33'(len_reg) + 33'd3) >> 2);
    assign cur_burst = burst_beats(remaining);

    assign arid_o    = AXI_ID;
    assign arsize_o  = AXI_SIZE_4B;
    assign arburst_o = AXI_BURST_INCR;
    assign araddr_o  = arvalid_o ? cur_src : 32'd0;
    assign arlen_o   = arvalid_o ? 4'(cur_burst - 5'd1) : 4'd0;
    assign awid_o    = AXI_ID;
    assign awsize_o  = AXI_SIZE_4B;
    assign awburst_o = AXI_BURST_INCR;
    assign awaddr_o  = awvalid_o ? cur_dst : 32'd0;
    assign awlen_o   = awvalid_o ? 4'(cur_burst - 5'd1) : 4'd0;
    assign wid_o     = AXI_ID;
    assign wstrb_o   = 4'hF;
    assign wdata_o   = wvalid_o ? fifo_rdata : 32'd0;
    assign wlast_o   = wvalid_o && (wbeat == 4'(cur_burst - 5'd1));

    assign fifo_push = rvalid_i & rready_o;
    assign fifo_pop  = wvalid_o & wready_i;

    dmac_fifo u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .wdata (rdata_i),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Register read-back, combinational from the address.
    always_comb begin
        prdata_o = 32'd0;
        case (paddr_i)
            REG_VERSION: prdata_o = VERSION;
            REG_SRC:     prdata_o = src_reg;
            REG_DST:     prdata_o = dst_reg;
            REG_LEN:     prdata_o = len_reg;
            REG_STATUS:  prdata_o = {31'd0, state == ST_IDLE};
            default:     prdata_o = 32'd0;
        endcase
    end

    // Programmable registers; writable at any time, the engine works on copies.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_reg <= '0;
            dst_reg <= '0;
            len_reg <= '0;
        end else if (apb_wr) begin
            case (paddr_i)
                REG_SRC: src_reg <= pwdata_i;
                REG_DST: dst_reg <= pwdata_i;
                REG_LEN: len_reg <= pwdata_i;
                default: ;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and channel valid/ready outputs.
    always_comb begin
        state_nxt = state;
        arvalid_o = 1'b0;
        rready_o  = 1'b0;
        awvalid_o = 1'b0;
        wvalid_o  = 1'b0;
        bready_o  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start_ok) state_nxt = ST_RREQ;
            end
            ST_RREQ: begin
                arvalid_o = 1'b1;
                if (arready_i) state_nxt = ST_RDATA;
            end
            ST_RDATA: begin
                rready_o = !fifo_full;
                if (fifo_push && rlast_i) state_nxt = ST_WREQ;
            end
            ST_WREQ: begin
                awvalid_o = 1'b1;
                if (awready_i) state_nxt = ST_WDATA;
            end
            ST_WDATA: begin
                wvalid_o = !fifo_empty;
                if (fifo_pop && wlast_o) state_nxt = ST_WRESP;
            end
            ST_WRESP: begin
                bready_o = 1'b1;
                if (bvalid_i) begin
                    state_nxt = (remaining != 31'(cur_burst)) ? ST_RREQ : ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Transfer bookkeeping: latched addresses, beats left, write beat index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_src   <= '0;
            cur_dst   <= '0;
            remaining <= '0;
            wbeat     <= '0;
        end else begin
            if (start_ok) begin
                cur_src   <= src_reg;
                cur_dst   <= dst_reg;
                remaining <= len_beats;
            end
            if (fifo_pop) begin
                wbeat <= wbeat + 4'd1;
            end
            if (state == ST_WRESP && bvalid_i) begin
                remaining <= remaining - 31'(cur_burst);
                cur_src   <= cur_src + {25'd0, cur_burst, 2'b00};
                cur_dst   <= cur_dst + {25'd0, cur_burst, 2'b00};
                wbeat     <= '0;
            end
        end
    end

endmodule

// File: tb/tb_dmac_top.sv
// Bench for dmac_top: APB driver tasks, an AXI slave model whose read data is
// a fixed function of address, and expected queues for APB reads, AR/AW
// requests and write beats checked whenever the DUT presents them.
module tb_dmac_top;

  logic        clk, rst_n;
  logic        psel_i, penable_i, pwrite_i;
  logic [11:0] paddr_i;
  logic [31:0] pwdata_i, prdata_o;
  logic        pready_o, pslverr_o;
  logic [3:0]  awid_o, arid_o, wid_o, awlen_o, arlen_o, wstrb_o, bid_i, rid_i;
  logic [31:0] awaddr_o, araddr_o, wdata_o, rdata_i;
  logic [2:0]  awsize_o, arsize_o;
  logic [1:0]  awburst_o, arburst_o, bresp_i, rresp_i;
  logic        awvalid_o, arvalid_o, awready_i, arready_i;
  logic        wlast_o, wvalid_o, wready_i, bvalid_i, bready_o;
  logic        rlast_i, rvalid_i, rready_o;

  dmac_top dut (
    .clk(clk), .rst_n(rst_n),
    .psel_i(psel_i), .penable_i(penable_i), .pwrite_i(pwrite_i),
    .paddr_i(paddr_i), .pwdata_i(pwdata_i), .pready_o(pready_o),
    .prdata_o(prdata_o), .pslverr_o(pslverr_o),
    .awid_o(awid_o), .awaddr_o(awaddr_o), .awlen_o(awlen_o), .awsize_o(awsize_o),
    .awburst_o(awburst_o), .awvalid_o(awvalid_o), .awready_i(awready_i),
    .wid_o(wid_o), .wdata_o(wdata_o), .wstrb_o(wstrb_o), .wlast_o(wlast_o),
    .wvalid_o(wvalid_o), .wready_i(wready_i),
    .bid_i(bid_i), .bresp_i(bresp_i), .bvalid_i(bvalid_i), .bready_o(bready_o),
    .arid_o(arid_o), .araddr_o(araddr_o), .arlen_o(arlen_o), .arsize_o(arsize_o),
    .arburst_o(arburst_o), .arvalid_o(arvalid_o), .arready_i(arready_i),
    .rid_i(rid_i), .rdata_i(rdata_i), .rresp_i(rresp_i), .rlast_i(rlast_i),
    .rvalid_i(rvalid_i), .rready_o(rready_o)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_rd_q[$];
  logic [35:0] exp_ar_q[$];
  logic [35:0] exp_aw_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] exp_wa_q[$];
  logic [3:0]  awlen_log[$];
  int exp_b_cnt = 0;
  int ar_count = 0;
  int aw_count = 0;
  bit stall_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got unexpected event expected none", name);
  endtask

  function automatic logic [31:0] pat(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_1234;
  endfunction

  function automatic bit coin();
    return !stall_en || ($urandom_range(0, 1) == 1);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic apb_write(input logic [11:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    psel_i = 1'b1; pwrite_i = 1'b1; paddr_i = a; pwdata_i = d; penable_i = 1'b0;
    @(posedge clk); #1;
    penable_i = 1'b1;
    @(posedge clk); #1;
    psel_i = 1'b0; penable_i = 1'b0; pwrite_i = 1'b0;
  endtask

  task automatic apb_read(input logic [11:0] a, input logic [31:0] exp);
    exp_rd_q.push_back(exp);
    @(posedge clk); #1;
    psel_i = 1'b1; pwrite_i = 1'b0; paddr_i = a; penable_i = 1'b0;
    @(posedge clk); #1;
    penable_i = 1'b1;
    @(posedge clk); #1;
    psel_i = 1'b0; penable_i = 1'b0;
  endtask

  // Expected AXI traffic for a copy: bursts of up to 16 beats, addresses +4.
  task automatic push_expect(input logic [31:0] src, input logic [31:0] dst, input logic [31:0] len);
    int left, done, b;
    left = int'((len + 32'd3) >> 2);
    done = 0;
    while (left > 0) begin
      b = (left > 16) ? 16 : left;
      exp_ar_q.push_back({src + 32'(4 * done), 4'(b - 1)});
      exp_aw_q.push_back({dst + 32'(4 * done), 4'(b - 1)});
      exp_b_cnt++;
      for (int j = 0; j < b; j++) begin
        exp_q.push_back(pat(src + 32'(4 * (done + j))));
        exp_wa_q.push_back(dst + 32'(4 * (done + j)));
      end
      done += b;
      left -= b;
    end
  endtask

  task automatic program_start(input logic [31:0] src, input logic [31:0] dst, input logic [31:0] len);
    apb_write(12'h100, src);
    apb_write(12'h104, dst);
    apb_write(12'h108, len);
    apb_write(12'h10C, 32'h1);
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while ((exp_ar_q.size() != 0 || exp_aw_q.size() != 0 || exp_q.size() != 0 ||
            exp_b_cnt != 0) && n < budget) begin
      @(posedge clk);
      n++;
    end
    check("xfer_complete", 64'(n < budget), 64'd1);
    apb_read(12'h110, 32'h1);
  endtask

  task automatic run_xfer(input logic [31:0] src, input logic [31:0] dst, input logic [31:0] len,
                          input int exp_bursts);
    int ar0, aw0;
    ar0 = ar_count;
    aw0 = aw_count;
    push_expect(src, dst, len);
    program_start(src, dst, len);
    apb_read(12'h110, 32'h0);
    wait_done(40000);
    check("ar_bursts", 64'(ar_count - ar0), 64'(exp_bursts));
    check("aw_bursts", 64'(aw_count - aw0), 64'(exp_bursts));
  endtask

  // ---------------- APB read monitor ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && psel_i && penable_i) begin
        check("pready", 64'(pready_o), 64'd1);
        check("pslverr", 64'(pslverr_o), 64'd0);
        if (!pwrite_i) begin
          if (exp_rd_q.size() == 0) fail("apb_read_unexpected");
          else check($sformatf("prdata_%h", paddr_i), 64'(prdata_o), 64'(exp_rd_q.pop_front()));
        end
      end
    end
  end

  // ---------------- AXI slave model and channel monitors ----------------
  initial begin
    logic [35:0] rd_bursts[$];
    logic [35:0] wr_bursts[$];
    int r_beat, w_beat, b_pend;
    bit r_hold, b_hold, last;
    r_beat = 0; w_beat = 0; b_pend = 0; r_hold = 0; b_hold = 0;
    arready_i = 0; awready_i = 0; wready_i = 0;
    rvalid_i = 0; rlast_i = 0; rdata_i = 0; rresp_i = 0; rid_i = 0;
    bvalid_i = 0; bresp_i = 0; bid_i = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        rd_bursts.delete(); wr_bursts.delete();
        r_beat = 0; w_beat = 0; b_pend = 0; r_hold = 0; b_hold = 0;
        arready_i = 0; awready_i = 0; wready_i = 0;
        rvalid_i = 0; rlast_i = 0; bvalid_i = 0;
      end else begin
        // B channel
        if (!b_hold) begin
          bvalid_i = (b_pend > 0) && coin();
          bresp_i  = 2'($urandom_range(0, 3));
        end
        if (bvalid_i && bready_o) begin
          b_pend--;
          exp_b_cnt--;
          b_hold = 0;
        end else b_hold = bvalid_i;
        // W channel
        wready_i = coin();
        if (wvalid_o && wready_i) begin
          if (wr_bursts.size() == 0 || exp_q.size() == 0) fail("w_unexpected");
          else begin
            last = (w_beat == int'(wr_bursts[0][3:0]));
            check("wlast", 64'(wlast_o), 64'(last));
            check("wstrb", 64'(wstrb_o), 64'hF);
            check("wdata", 64'(wdata_o), 64'(exp_q.pop_front()));
            check("waddr", 64'(wr_bursts[0][35:4] + 32'(4 * w_beat)), 64'(exp_wa_q.pop_front()));
            w_beat++;
            if (last) begin
              void'(wr_bursts.pop_front());
              w_beat = 0;
              b_pend++;
            end
          end
        end
        // AW channel
        awready_i = coin();
        if (awvalid_o && awready_i) begin
          if (exp_aw_q.size() == 0) fail("aw_unexpected");
          else check("aw_addr_len", 64'({awaddr_o, awlen_o}), 64'(exp_aw_q.pop_front()));
          check("aw_const", 64'({awid_o, wid_o, awsize_o, awburst_o}), 64'({4'd0, 4'd0, 3'b010, 2'b01}));
          wr_bursts.push_back({awaddr_o, awlen_o});
          awlen_log.push_back(awlen_o);
          aw_count++;
        end
        // R channel: only bursts accepted on an earlier cycle
        if (!r_hold) begin
          if (rd_bursts.size() > 0 && coin()) begin
            rvalid_i = 1;
            rdata_i  = pat(rd_bursts[0][35:4] + 32'(4 * r_beat));
            rlast_i  = (r_beat == int'(rd_bursts[0][3:0]));
            rresp_i  = 2'($urandom_range(0, 3));
          end else begin
            rvalid_i = 0;
            rlast_i  = 0;
          end
        end
        if (rvalid_i && rready_o) begin
          r_hold = 0;
          r_beat++;
          if (rlast_i) begin
            void'(rd_bursts.pop_front());
            r_beat = 0;
          end
        end else r_hold = rvalid_i;
        // AR channel
        arready_i = coin();
        if (arvalid_o && arready_i) begin
          if (exp_ar_q.size() == 0) fail("ar_unexpected");
          else check("ar_addr_len", 64'({araddr_o, arlen_o}), 64'(exp_ar_q.pop_front()));
          check("ar_const", 64'({arid_o, arsize_o, arburst_o}), 64'({4'd0, 3'b010, 2'b01}));
          rd_bursts.push_back({araddr_o, arlen_o});
          ar_count++;
        end
      end
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    int ar0, n;
    rst_n = 0; psel_i = 0; penable_i = 0; pwrite_i = 0; paddr_i = 0; pwdata_i = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valids", 64'({arvalid_o, awvalid_o, wvalid_o, rready_o, bready_o}), 64'd0);
    check("rst_axi_addr", 64'({araddr_o, awaddr_o}), 64'd0);
    check("rst_axi_len", 64'({arlen_o, awlen_o}), 64'd0);
    rst_n = 1;

    // Reset values and read-only / unmapped addresses
    apb_read(12'h100, 32'h0);
    apb_read(12'h104, 32'h0);
    apb_read(12'h108, 32'h0);
    apb_read(12'h110, 32'h1);
    apb_read(12'h000, 32'h0001_0101);
    apb_read(12'h10C, 32'h0);
    apb_read(12'h200, 32'h0);

    // Aligned 256-byte copy: four 16-beat bursts each way
    run_xfer(32'h1000, 32'h2000, 32'h100, 4);
    // Unaligned 64-byte copy: one 16-beat burst each way
    run_xfer(32'h0000_C8ED, 32'h1234, 32'h40, 1);
    // Long copy, then the same with random stalls on every channel
    run_xfer(32'h0101, 32'h1010, 32'h2480, 146);
    stall_en = 1'b1;
    run_xfer(32'h0101, 32'h1010, 32'h2480, 146);
    stall_en = 1'b0;

    // 0x44 bytes: 16 then 1 beat; a start written while busy is ignored
    ar0 = ar_count;
    awlen_log.delete();
    push_expect(32'h3000, 32'h4000, 32'h44);
    program_start(32'h3000, 32'h4000, 32'h44);
    apb_write(12'h100, 32'h7000);
    apb_write(12'h104, 32'h8000);
    apb_write(12'h108, 32'h8);
    apb_write(12'h10C, 32'h1);
    wait_done(5000);
    repeat (30) @(posedge clk);
    check("busy_start_ignored", 64'(ar_count - ar0), 64'd2);
    check("awlen_first", 64'(awlen_log.size() > 0 ? awlen_log[0] : 4'hX), 64'd15);
    check("awlen_second", 64'(awlen_log.size() > 1 ? awlen_log[1] : 4'hX), 64'd0);
    apb_read(12'h100, 32'h7000);
    apb_read(12'h104, 32'h8000);
    apb_read(12'h108, 32'h8);

    // Zero length start stays idle
    ar0 = ar_count;
    apb_write(12'h108, 32'h0);
    apb_write(12'h10C, 32'h1);
    apb_read(12'h110, 32'h1);
    repeat (20) @(posedge clk);
    check("len0_no_ar", 64'(ar_count - ar0), 64'd0);

    // Reset in the middle of a transfer
    ar0 = ar_count;
    push_expect(32'h1000, 32'h3000, 32'h100);
    program_start(32'h1000, 32'h3000, 32'h100);
    n = 0;
    while (ar_count < ar0 + 2 && n < 2000) begin
      @(posedge clk);
      n++;
    end
    check("mid_reached", 64'(n < 2000), 64'd1);
    repeat (5) @(posedge clk);
    #2;
    rst_n = 0;
    #1;
    check("abort_valids", 64'({arvalid_o, awvalid_o, wvalid_o, rready_o, bready_o}), 64'd0);
    check("abort_status", 64'(prdata_o[0] | (paddr_i != 12'h110)), 64'd1);
    exp_ar_q.delete(); exp_aw_q.delete(); exp_q.delete(); exp_wa_q.delete();
    exp_b_cnt = 0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1;
    apb_read(12'h110, 32'h1);
    apb_read(12'h100, 32'h0);
    run_xfer(32'h0500, 32'h0600, 32'h20, 1);

    check("apb_reads_drained", 64'(exp_rd_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
